// File: rtl/ppu_pkg.sv
// Shared pixel-pipeline types: mixer state encoding and derived bus widths.
package ppu_pkg;

  typedef enum logic [1:0] {
    StWait  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2
  } mix_state_e;

  function automatic int unsigned calc_src_w(input int unsigned num_layers);
    return (num_layers <= 1) ? 1 : $clog2(num_layers);
  endfunction

  function automatic int unsigned calc_pix_w(input int unsigned num_layers,
                                             input int unsigned pal_w,
                                             input int unsigned color_w);
    return calc_src_w(num_layers) + pal_w + color_w;
  endfunction

endpackage

// File: rtl/layer_prio_select.sv
// Picks the visible layer: highest priority among enabled opaque layers,
// ties resolved toward the higher layer index. Outputs zero when none qualify.
module layer_prio_select
  import ppu_pkg::*;
#(
  parameter  int unsigned NUM_LAYERS = 3,
  parameter  int unsigned PAL_W      = 5,
  parameter  int unsigned COLOR_W    = 4,
  localparam int unsigned SRC_W      = calc_src_w(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0]                 i_en,
  input  logic [NUM_LAYERS*(PAL_W+COLOR_W)-1:0] i_pix,
  input  logic [NUM_LAYERS*2-1:0]               i_prio,
  output logic [SRC_W-1:0]                      o_src,
  output logic [PAL_W-1:0]                      o_pal,
  output logic [COLOR_W-1:0]                    o_color
);

  localparam int unsigned LW = PAL_W + COLOR_W;

  logic       w_found;
  logic [1:0] w_best_prio;

  always_comb begin
    w_found     = 1'b0;
    w_best_prio = '0;
    o_src       = '0;
    o_pal       = '0;
    o_color     = '0;
    // Ascending scan with >= lets a later (higher) index win equal ranks.
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (i_en[i] && (i_pix[i*LW +: COLOR_W] != '0) &&
          (!w_found || (i_prio[i*2 +: 2] >= w_best_prio))) begin
        w_found     = 1'b1;
        w_best_prio = i_prio[i*2 +: 2];
        o_src       = SRC_W'(i);
        o_pal       = i_pix[i*LW+COLOR_W +: PAL_W];
        o_color     = i_pix[i*LW +: COLOR_W];
      end
    end
  end

endmodule

// File: rtl/up_counter.sv
// Free-running up counter with synchronous clear and count enable.
module up_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/layer_mixer.sv
// Row mixer: waits for every enabled layer engine to finish fetching, sweeps the
// row columns, and writes the priority-selected pixel of each column to row RAM.
module layer_mixer
  import ppu_pkg::*;
#(
  parameter  int unsigned NUM_LAYERS = 3,
  parameter  int unsigned ROW_PIXELS = 320,
  parameter  int unsigned ADDR_W     = 9,
  parameter  int unsigned COLOR_W    = 4,
  parameter  int unsigned PAL_W      = 5,
  parameter  int unsigned RD_LAT     = 1,
  localparam int unsigned SRC_W      = calc_src_w(NUM_LAYERS),
  localparam int unsigned PIX_W      = calc_pix_w(NUM_LAYERS, PAL_W, COLOR_W)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_LAYERS-1:0]                 layer_en,
  input  logic [NUM_LAYERS-1:0]                 layer_done,
  output logic [ADDR_W-1:0]                     pixel_addr,
  input  logic [NUM_LAYERS*(PAL_W+COLOR_W)-1:0] layer_pix,
  input  logic [NUM_LAYERS*2-1:0]               layer_prio,
  output logic [PIX_W-1:0]                      rowram_wrdata,
  output logic [ADDR_W-1:0]                     rowram_wraddr,
  output logic                                  rowram_wren,
  output logic                                  busy,
  output logic                                  row_done
);

  localparam int unsigned DRAIN_W = $clog2(RD_LAT + 1);

  mix_state_e r_state, w_state_next;

  logic [NUM_LAYERS-1:0] r_done_rec;
  logic [DRAIN_W-1:0]    r_drain_cnt;
  logic [RD_LAT-1:0]     r_vld;
  logic [ADDR_W-1:0]     r_adr [RD_LAT];
  logic                  r_wren;
  logic [ADDR_W-1:0]     r_wraddr;
  logic [PIX_W-1:0]      r_wrdata;
  logic                  r_row_done;

  logic               w_ready, w_last_col, w_drain_last;
  logic               w_cnt_clr, w_cnt_en, w_issue;
  logic [SRC_W-1:0]   w_src;
  logic [PAL_W-1:0]   w_pal;
  logic [COLOR_W-1:0] w_color;

  // A done pulse arriving this cycle counts toward the start condition.
  assign w_ready      = &(r_done_rec | layer_done | ~layer_en);
  assign w_last_col   = (pixel_addr == ADDR_W'(ROW_PIXELS - 1));
  assign w_drain_last = (r_drain_cnt == DRAIN_W'(RD_LAT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StWait;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StWait:  if (w_ready)      w_state_next = StFetch;
      StFetch: if (w_last_col)   w_state_next = StDrain;
      StDrain: if (w_drain_last) w_state_next = StWait;
      default:                   w_state_next = StWait;
    endcase
  end

  always_comb begin
    busy      = (r_state != StWait);
    w_issue   = (r_state == StFetch);
    w_cnt_en  = (r_state == StFetch) && !w_last_col;
    // Clearing on the last drain cycle keeps pixel_addr at 0 throughout WAIT.
    w_cnt_clr = (r_state == StWait) || ((r_state == StDrain) && w_drain_last);
  end

  up_counter #(
    .WIDTH (ADDR_W)
  ) u_addr_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (pixel_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_rec  <= '0;
      r_drain_cnt <= '0;
    end else begin
      if ((r_state == StWait) && w_ready) begin
        r_done_rec <= layer_done;
      end else begin
        r_done_rec <= r_done_rec | layer_done;
      end
      r_drain_cnt <= (r_state == StDrain) ? r_drain_cnt + DRAIN_W'(1) : '0;
    end
  end

  layer_prio_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .PAL_W      (PAL_W),
    .COLOR_W    (COLOR_W)
  ) u_prio_select (
    .i_en    (layer_en),
    .i_pix   (layer_pix),
    .i_prio  (layer_prio),
    .o_src   (w_src),
    .o_pal   (w_pal),
    .o_color (w_color)
  );

  // Stage RD_LAT-1 lines up with engine data for its address; the output
  // registers form the final stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld      <= '0;
      for (int k = 0; k < RD_LAT; k++) r_adr[k] <= '0;
      r_wren     <= 1'b0;
      r_wraddr   <= '0;
      r_wrdata   <= '0;
      r_row_done <= 1'b0;
    end else begin
      r_vld[0] <= w_issue;
      r_adr[0] <= pixel_addr;
      for (int k = 1; k < RD_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_adr[k] <= r_adr[k-1];
      end
      r_wren     <= r_vld[RD_LAT-1];
      r_wraddr   <= r_adr[RD_LAT-1];
      r_wrdata   <= r_vld[RD_LAT-1] ? {w_src, w_pal, w_color} : '0;
      r_row_done <= (r_state == StDrain) && w_drain_last;
    end
  end

  assign rowram_wren   = r_wren;
  assign rowram_wraddr = r_wraddr;
  assign rowram_wrdata = r_wrdata;
  assign row_done      = r_row_done;

endmodule

// File: doc/layer_mixer.md
LAYER_MIXER -- requirements
Module: layer_mixer

Interface
REQ-001 Parameter NUM_LAYERS, default 3, number of pixel-engine layers; index 0 is the backmost layer.
REQ-002 Parameter ROW_PIXELS, default 320, pixels written per row.
REQ-003 Parameter ADDR_W, default 9, pixel address width; ROW_PIXELS SHALL be <= 2**ADDR_W.
REQ-004 Parameter COLOR_W, default 4, color index width; value 0 means transparent.
REQ-005 Parameter PAL_W, default 5, palette address width per layer.
REQ-006 Parameter RD_LAT, default 1, engine read latency in cycles (1..4).
REQ-007 Derived SRC_W = max(1, clog2(NUM_LAYERS)); PIX_W = SRC_W+PAL_W+COLOR_W.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 layer_en  in  NUM_LAYERS  per-layer enable, sampled every cycle.
REQ-011 layer_done  in  NUM_LAYERS  per-layer single-cycle "row fetched" pulse.
REQ-012 pixel_addr  out  ADDR_W  column presented to all engines.
REQ-013 layer_pix  in  NUM_LAYERS*(PAL_W+COLOR_W)  per layer {palette,color}, valid RD_LAT cycles after pixel_addr.
REQ-014 layer_prio  in  NUM_LAYERS*2  per-layer priority rank, same timing as layer_pix.
REQ-015 rowram_wrdata  out  PIX_W  {source layer, palette, color}.
REQ-016 rowram_wraddr  out  ADDR_W  write column.
REQ-017 rowram_wren  out  1  write strobe.
REQ-018 busy  out  1  high in FETCH and DRAIN.
REQ-019 row_done  out  1  single-cycle pulse after the last write of a row.

Function
REQ-020 States WAIT, FETCH, DRAIN; WAIT after reset.
REQ-021 Per-layer done_rec flag SHALL be set by layer_done in any state; cleared on the WAIT->FETCH edge unless layer_done for that layer is high that same cycle (set wins).
REQ-022 WAIT->FETCH when, for every layer, done_rec or !layer_en; all layers disabled SHALL start FETCH on the next cycle.
REQ-023 FETCH: pixel_addr starts at 0, increments by 1 per cycle, FETCH->DRAIN after addressing ROW_PIXELS-1; pixel_addr SHALL be 0 in WAIT and hold at ROW_PIXELS-1 in DRAIN.
REQ-024 Issued addresses SHALL travel a valid/address pipeline of depth RD_LAT+1; rowram_wren and rowram_wraddr are its output, so column c is written exactly RD_LAT+1 cycles after pixel_addr==c.
REQ-025 Exactly ROW_PIXELS writes per row, addresses 0..ROW_PIXELS-1 in order, no gaps, no duplicates.
REQ-026 DRAIN lasts RD_LAT+1 cycles; row_done pulses the cycle after the final write; state returns to WAIT in that same cycle.
REQ-027 Mixing: a layer is a candidate when enabled and its color != 0; the winner is the candidate with the highest prio rank, ties broken by higher layer index.
REQ-028 rowram_wrdata = {winner index, winner palette, winner color}, registered with the pipeline's final stage; no candidate -> all-zero backdrop.
REQ-029 layer_en SHALL be applied at mix time (RD_LAT cycles after address), not latched per row.
REQ-030 rowram_wrdata SHALL be 0 whenever rowram_wren is 0.

Reset
REQ-031 Asynchronous rst_n low SHALL force: state WAIT, done_rec all 0, pixel_addr 0, pipeline valids 0, rowram_wren 0, rowram_wraddr 0, rowram_wrdata 0, busy 0, row_done 0.
REQ-032 Reset mid-row SHALL abort the row; no further writes until a complete new done set arrives.

Structure
REQ-033 State enum and the PIX_W/SRC_W derivation functions SHALL live in shared package ppu_pkg.
REQ-034 Priority selection SHALL be one combinational sub-module, layer_prio_select, parametrised by NUM_LAYERS, PAL_W, COLOR_W.
REQ-035 Address counter SHALL reuse the existing up_counter block.

Verification
REQ-036 Defaults, all enabled, done pulses on cycles 5,7,9 -> FETCH begins cycle 10; 320 writes, first wraddr 0 at +2 cycles, row_done once, busy high 322 cycles.
REQ-037 Layer0 color 3 pal 2 prio 0, layer2 color 5 pal 7 prio 2 -> wrdata {2,7,5}; layer2 color 0 -> {0,2,3}; all colors 0 -> 0.
REQ-038 Equal prio 1 on layers 1 and 2, both opaque -> source 2; layer_en[2]=0 -> source 1.
REQ-039 RD_LAT=3, NUM_LAYERS=5, ROW_PIXELS=256 -> writes at pixel_addr+4 cycles, exactly 256 writes, SRC_W=3.
REQ-040 layer_done[1] pulsed during FETCH -> next row starts as soon as remaining dones arrive; layer_done in WAIT->FETCH cycle retained.
REQ-041 rst_n asserted at column 100 -> all outputs 0 immediately; no writes until all done pulses reappear.
